bg_eraser_core: RTL

- Sits directly downstream of the camera/reference stream aligner and consumes its two pixel streams (camera "new" and stored "ref").
- When both streams present a beat, it computes the per-pixel RGB888 distance and replaces background pixels with a fill colour. Foreground pixels are passed unchanged.
- Output is one AXI4-Stream-style video stream towards the VDMA/display path.
- Its s_*_tready outputs drive the aligner's treadyOut_new and treadyOut_ref inputs.

---
 rtl/bg_eraser_core_if.sv | 41 ++++
 rtl/bg_eraser_core.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/bg_eraser_core_if.sv
// Stream bundle for bg_eraser_core: the camera/reference input pair and the video output.
// The core uses the slave view; whatever feeds and drains it uses the master view.
interface bg_eraser_core_if #(
  parameter int DATA_W = 24
);
  logic [DATA_W-1:0] s_new_tdata;
  logic              s_new_tvalid;
  logic              s_new_tuser;
  logic              s_new_tlast;
  logic              s_new_tready;

  logic [DATA_W-1:0] s_ref_tdata;
  logic              s_ref_tvalid;
  logic              s_ref_tuser;
  logic              s_ref_tlast;
  logic              s_ref_tready;

  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tuser;
  logic              m_tlast;
  logic              m_tready;

  modport slave (
    input  s_new_tdata, s_new_tvalid, s_new_tuser, s_new_tlast,
    output s_new_tready,
    input  s_ref_tdata, s_ref_tvalid, s_ref_tuser, s_ref_tlast,
    output s_ref_tready,
    output m_tdata, m_tvalid, m_tuser, m_tlast,
    input  m_tready
  );

  modport master (
    output s_new_tdata, s_new_tvalid, s_new_tuser, s_new_tlast,
    input  s_new_tready,
    output s_ref_tdata, s_ref_tvalid, s_ref_tuser, s_ref_tlast,
    input  s_ref_tready,
    input  m_tdata, m_tvalid, m_tuser, m_tlast,
    output m_tready
  );
endinterface

// File: rtl/bg_eraser_core.sv
// Background eraser: replaces pixels close to the reference frame with a fill colour.
// Define BG_ERASER_STATS_EN to add the per-frame foreground counter (fg_count/frame_done).
module bg_eraser_core #(
  parameter int          DATA_W      = 24,
  parameter logic [9:0]  THR_DEFAULT = 10'd48,
  parameter logic [23:0] BG_DEFAULT  = 24'h000000,
  parameter int          FG_CNT_W    = 19
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         enable,
  input  logic [9:0]   threshold,
  input  logic [23:0]  bg_color,
  bg_eraser_core_if.slave vid,
  output logic         sync_err
`ifdef BG_ERASER_STATS_EN
  ,
  output logic [FG_CNT_W-1:0] fg_count,
  output logic                frame_done
`endif
);

  function automatic logic [7:0] absDiff(input logic [7:0] a, input logic [7:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  logic w_adv;
  logic w_paired;

  logic              r_s1Valid;
  logic              r_s1Pair;
  logic              r_s1User;
  logic              r_s1Last;
  logic [DATA_W-1:0] r_s1Data;
  logic [7:0]        r_s1DiffR;
  logic [7:0]        r_s1DiffG;
  logic [7:0]        r_s1DiffB;
  logic              r_syncErr;

  logic              r_s2Valid;
  logic              r_s2Pair;
  logic              r_s2Fg;
  logic              r_mUser;
  logic              r_mLast;
  logic [DATA_W-1:0] r_mData;
  logic [9:0]        r_thr;
  logic [23:0]       r_bg;

  logic [9:0]        w_sum;
  logic              w_sof;
  logic [9:0]        w_thrEff;
  logic [23:0]       w_bgEff;
  logic              w_fg;

  // Stall-all: both inputs are ready exactly when the output stage can move.
  assign w_adv    = !r_s2Valid || vid.m_tready;
  assign w_paired = vid.s_new_tvalid && vid.s_ref_tvalid;

  assign vid.s_new_tready = w_adv;
  assign vid.s_ref_tready = w_adv;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s1Valid <= 1'b0;
      r_s1Pair  <= 1'b0;
      r_s1User  <= 1'b0;
      r_s1Last  <= 1'b0;
      r_s1Data  <= '0;
      r_s1DiffR <= '0;
      r_s1DiffG <= '0;
      r_s1DiffB <= '0;
      r_syncErr <= 1'b0;
    end else begin
      r_syncErr <= w_adv && w_paired &&
                   ((vid.s_new_tuser != vid.s_ref_tuser) || (vid.s_new_tlast != vid.s_ref_tlast));
      if (w_adv) begin
        // A ref-only beat is swallowed here: only a new beat makes S1 valid.
        r_s1Valid <= vid.s_new_tvalid;
        r_s1Pair  <= w_paired && enable;
        r_s1User  <= vid.s_new_tuser;
        r_s1Last  <= vid.s_new_tlast;
        r_s1Data  <= vid.s_new_tdata;
        r_s1DiffR <= absDiff(vid.s_new_tdata[23:16], vid.s_ref_tdata[23:16]);
        r_s1DiffG <= absDiff(vid.s_new_tdata[15:8],  vid.s_ref_tdata[15:8]);
        r_s1DiffB <= absDiff(vid.s_new_tdata[7:0],   vid.s_ref_tdata[7:0]);
      end
    end
  end

  // The SOF beat itself must already see the freshly loaded threshold and colour.
  assign w_sof    = r_s1Valid && r_s1User;
  assign w_sum    = {2'b00, r_s1DiffR} + {2'b00, r_s1DiffG} + {2'b00, r_s1DiffB};
  assign w_thrEff = w_sof ? threshold : r_thr;
  assign w_bgEff  = w_sof ? bg_color  : r_bg;
  assign w_fg     = (w_sum > w_thrEff);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s2Valid <= 1'b0;
      r_s2Pair  <= 1'b0;
      r_s2Fg    <= 1'b0;
      r_mUser   <= 1'b0;
      r_mLast   <= 1'b0;
      r_mData   <= '0;
      r_thr     <= THR_DEFAULT;
      r_bg      <= BG_DEFAULT;
    end else if (w_adv) begin
      r_s2Valid <= r_s1Valid;
      r_s2Pair  <= r_s1Pair;
      r_s2Fg    <= w_fg;
      r_mUser   <= r_s1User;
      r_mLast   <= r_s1Last;
      r_mData   <= (r_s1Pair && !w_fg) ? w_bgEff : r_s1Data;
      if (w_sof) begin
        r_thr <= threshold;
        r_bg  <= bg_color;
      end
    end
  end

  assign vid.m_tdata  = r_mData;
  assign vid.m_tvalid = r_s2Valid;
  assign vid.m_tuser  = r_mUser;
  assign vid.m_tlast  = r_mLast;
  assign sync_err     = r_syncErr;

`ifdef BG_ERASER_STATS_EN
  logic                w_hs;
  logic                w_fgBeat;
  logic [FG_CNT_W-1:0] r_cnt;
  logic [FG_CNT_W-1:0] r_fgCount;
  logic                r_frameDone;

  assign w_hs     = r_s2Valid && vid.m_tready;
  assign w_fgBeat = r_s2Pair && r_s2Fg;

  // SOF handshake closes the previous frame and seeds the count with the SOF beat itself.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt       <= '0;
      r_fgCount   <= '0;
      r_frameDone <= 1'b0;
    end else begin
      r_frameDone <= w_hs && r_mUser;
      if (w_hs) begin
        if (r_mUser) begin
          r_fgCount <= r_cnt;
          r_cnt     <= {{(FG_CNT_W-1){1'b0}}, w_fgBeat};
        end else if (w_fgBeat && (r_cnt != {FG_CNT_W{1'b1}})) begin
          r_cnt <= r_cnt + {{(FG_CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign fg_count   = r_fgCount;
  assign frame_done = r_frameDone;
`endif

endmodule
